// File: rtl/mod_state_fifo.sv
// Round-state FIFO for the AES datapath: selects the round result by round tag, queues it with
// round/last tags behind valid/ready handshakes, flags illegal rounds and counts finished blocks.
module mod_state_fifo #(
   parameter int unsigned N     = 16,
   parameter int unsigned W     = 8,
   parameter int unsigned NR    = 14,
   parameter int unsigned RW    = 4,
   parameter int unsigned DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [RW-1:0]   in_round,
   input  logic [N*W-1:0]  inp_init,
   input  logic [N*W-1:0]  inp_mC,
   input  logic [N*W-1:0]  inp_shf,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*W-1:0]  out_data,
   output logic [RW-1:0]   out_round,
   output logic            out_last,
   output logic            err_round,
   output logic [15:0]     blocks_done
);

   localparam int unsigned DW = N * W;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DW-1:0]    mem_data  [DEPTH];
   logic [RW-1:0]    mem_round [DEPTH];
   logic [DEPTH-1:0] mem_last;

   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   logic          err_q;
   logic [15:0]   blocks_q;

   logic [DW-1:0] sel_data;
   logic          sel_last;
   logic          illegal;
   logic          push_acc;
   logic          wr_en;
   logic          rd_en;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      sel_data = inp_mC;
      if (in_round == '0) begin
         sel_data = inp_init;
      end else if (in_round == RW'(NR)) begin
         sel_data = inp_shf;
      end
   end

   assign sel_last = (in_round == RW'(NR));
   assign illegal  = (in_round > RW'(NR));

   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);

   // An illegal round still completes the handshake but never reaches storage.
   assign push_acc = in_valid && in_ready && !flush;
   assign wr_en    = push_acc && !illegal;
   assign rd_en    = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         blocks_q <= '0;
         mem_last <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i]  <= '0;
            mem_round[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_data[wr_ptr_q]  <= sel_data;
            mem_round[wr_ptr_q] <= in_round;
            mem_last[wr_ptr_q]  <= sel_last;
            wr_ptr_q            <= ptr_inc(wr_ptr_q);
         end
         if (rd_en) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (out_last) begin
               blocks_q <= blocks_q + 16'd1;
            end
         end
         if (push_acc && illegal) begin
            err_q <= 1'b1;
         end
         unique case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign out_data    = mem_data[rd_ptr_q];
   assign out_round   = mem_round[rd_ptr_q];
   assign out_last    = mem_last[rd_ptr_q];
   assign err_round   = err_q;
   assign blocks_done = blocks_q;

endmodule

// File: doc/mod_state_fifo.md
Name: mod_state_fifo

Overview:
- Parametrised successor to the single-stage round-state register in the AES256 datapath.
- Each cycle it selects the round result from one of three sources:
  - initial AddRoundKey for round 0,
  - ShiftRows for the final round,
  - MixColumns for all other rounds.
- The selected result is stored in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between the round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey) and the next round's input mux or the ciphertext output stage. It adds backpressure, round tagging, last-round flagging and error detection.

Parameters:
- N, 16, number of bytes in the state.
- W, 8, bits per byte.
- NR, 14, final round number (14 for AES-256; 10/12 allowed).
- RW, 4, width of the round tag.
- DEPTH, 2, FIFO entries; legal values 1, 2 or 4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO contents and error flag.
- in_valid  input  1  source presents a round result.
- in_ready  output  1  block can accept this cycle.
- in_round  input  RW  round number of the presented result.
- inp_init  input  N*W  round-0 (initial AddRoundKey) state.
- inp_mC  input  N*W  MixColumns-path state.
- inp_shf  input  N*W  ShiftRows-path state (final round).
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  N*W  head state; byte i at bits [i*W +: W].
- out_round  output  RW  round tag of head.
- out_last  output  1  head round == NR.
- err_round  output  1  sticky; an accepted round exceeded NR.
- blocks_done  output  16  count of popped entries with out_last=1.

Behaviour:
- Reset (reset=1 at clk edge): count, read/write pointers, storage, out_valid, out_data, out_round, out_last, err_round and blocks_done all go to 0. in_ready is 1 after reset. Reset overrides flush, push and pop.
- Source select at accept, by in_round:
  - 0 -> inp_init.
  - NR -> inp_shf.
  - 1..NR-1 -> inp_mC.
  - >NR -> illegal.
- Push: occurs when in_valid && in_ready. in_ready = (count < DEPTH), purely from registered count; no combinational path from out_ready.
- Each entry stores {data, round, last}, with last = (round == NR).
- Illegal round:
  - The handshake completes normally (in_ready unaffected).
  - The entry is NOT written and count is not incremented.
  - err_round is set the next cycle and stays 1 until reset or flush.
- Pop: occurs when out_valid && out_ready. out_valid = (count != 0). out_data, out_round and out_last are driven from the head entry (read-pointer mux, no extra register).
- Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal in every state with count >= 1. When count == DEPTH, in_ready=0, so no push occurs in that cycle even if a pop does.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Popped entries are not cleared in storage. out_data is don't-care while out_valid=0, but must read 0 after reset.
- blocks_done increments by 1 on each pop with out_last=1 and wraps from 0xFFFF to 0. It is unaffected by flush.
- flush=1 (reset=0):
  - Next cycle count=0, pointers=0, err_round=0.
  - Any push or pop in the same cycle is discarded; blocks_done does not count it.
  - Storage contents are not cleared.
- Source inputs are sampled only on push. Input changes while in_ready=0 have no effect.

Test Plan:
- Reset then idle:
  - Required: all outputs are 0 and in_ready=1.
- Single round-0 push, data byte i = i:
  - Required: out_valid=1 next cycle, out_round=0, out_last=0, out_data byte i = i.
  - Pop clears out_valid.
- DEPTH=2 fill:
  - Stimulus: push rounds 5 and 6 with out_ready=0.
  - Required: in_ready=0 after the second push.
  - Raise out_ready for 2 cycles: heads come out as round 5 then 6 in order with inp_mC data; in_ready returns to 1.
- Final round:
  - Stimulus: in_round=14, inp_shf=0xAA.., inp_mC=0x55...
  - Required: out_data=0xAA.., out_last=1. Popping it gives blocks_done=1.
- Illegal round 15:
  - Stimulus: push in_round=15.
  - Required: handshake completes, out_valid stays 0, err_round=1 next cycle and persists.
  - flush clears err_round.
- Streaming:
  - Stimulus: in_valid=out_ready=1 for 20 cycles with rounds 1..14 incrementing.
  - Required: one entry per cycle after a 1-cycle latency.
  - Mid-stream reset: the cycle after reset, out_valid=0 and count=0.
